jk_bank_sched: RTL and testbench

Scheduler that shares one WIDTH-bit bank of JK flip-flops between two requesters. Each requester issues a JK command (hold/reset/set/toggle), a bit mask and a repeat count; the block arbitrates round-robin, latches the winning command and applies it to the masked bits for (count+1) consecutive clock edges. It sits between control logic and the JK storage bank and is the only writer of that bank.

---
 rtl/jk_bank_sched_if.sv | 30 +++
 rtl/jk_bank_sched.sv | 132 +++++++++++++
 tb/tb_jk_bank_sched.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jk_bank_sched_if.sv
// Requester/scheduler bundle for jk_bank_sched: two JK command ports plus grant/status and bank state.
interface jk_bank_sched_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = 4
);
  logic             req_a;
  logic [1:0]       op_a;
  logic [WIDTH-1:0] mask_a;
  logic [CW-1:0]    cnt_a;
  logic             req_b;
  logic [1:0]       op_b;
  logic [WIDTH-1:0] mask_b;
  logic [CW-1:0]    cnt_b;
  logic             gnt_a;
  logic             gnt_b;
  logic             busy;
  logic             owner;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;

  modport master (
    output req_a, op_a, mask_a, cnt_a, req_b, op_b, mask_b, cnt_b,
    input  gnt_a, gnt_b, busy, owner, q, qbar
  );

  modport slave (
    input  req_a, op_a, mask_a, cnt_a, req_b, op_b, mask_b, cnt_b,
    output gnt_a, gnt_b, busy, owner, q, qbar
  );
endinterface

// File: rtl/jk_bank_sched.sv
// Round-robin scheduler that applies latched JK commands from two requesters to a shared bank
// of WIDTH flip-flops for (cnt+1) consecutive edges.
module jk_bank_sched #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  jk_bank_sched_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_mask;
  logic [CW-1:0]    r_rem;
  logic             r_owner;
  logic             r_gnt_a;
  logic             r_gnt_b;
  logic             r_busy;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qbar;

  logic [1:0]       w_op_nxt;
  logic [WIDTH-1:0] w_mask_nxt;
  logic [CW-1:0]    w_rem_nxt;
  logic             w_owner_nxt;
  logic             w_gnt_a_nxt;
  logic             w_gnt_b_nxt;
  logic             w_busy_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_jk_val;
  logic             w_req_any;
  logic             w_win_b;

  // r_owner doubles as last_owner: on a tie the requester not served last wins
  assign w_req_any = bus.req_a | bus.req_b;
  assign w_win_b   = bus.req_b & (~bus.req_a | ~r_owner);

  // value every masked bit takes under the latched JK code
  always_comb begin
    w_jk_val = r_q;
    unique case (r_op)
      2'd0:    w_jk_val = r_q;
      2'd1:    w_jk_val = '0;
      2'd2:    w_jk_val = '1;
      default: w_jk_val = ~r_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_req_any) w_state_nxt = S_RUN;
      S_RUN:   if (r_rem == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_op_nxt    = r_op;
    w_mask_nxt  = r_mask;
    w_rem_nxt   = r_rem;
    w_owner_nxt = r_owner;
    w_gnt_a_nxt = 1'b0;
    w_gnt_b_nxt = 1'b0;
    w_busy_nxt  = r_busy;
    w_q_nxt     = r_q;
    unique case (r_state)
      S_IDLE: begin
        if (w_req_any) begin
          w_owner_nxt = w_win_b;
          w_op_nxt    = w_win_b ? bus.op_b   : bus.op_a;
          w_mask_nxt  = w_win_b ? bus.mask_b : bus.mask_a;
          w_rem_nxt   = w_win_b ? bus.cnt_b  : bus.cnt_a;
          w_gnt_a_nxt = ~w_win_b;
          w_gnt_b_nxt = w_win_b;
          w_busy_nxt  = 1'b1;
        end
      end
      S_RUN: begin
        w_q_nxt = (r_q & ~r_mask) | (w_jk_val & r_mask);
        if (r_rem == '0) w_busy_nxt = 1'b0;
        else             w_rem_nxt  = r_rem - CW'(1);
      end
      default: ;
    endcase
  end

  // qbar is registered from the same next value so it tracks ~q every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_mask  <= '0;
      r_rem   <= '0;
      r_owner <= 1'b1;
      r_gnt_a <= 1'b0;
      r_gnt_b <= 1'b0;
      r_busy  <= 1'b0;
      r_q     <= '0;
      r_qbar  <= '1;
    end else begin
      r_op    <= w_op_nxt;
      r_mask  <= w_mask_nxt;
      r_rem   <= w_rem_nxt;
      r_owner <= w_owner_nxt;
      r_gnt_a <= w_gnt_a_nxt;
      r_gnt_b <= w_gnt_b_nxt;
      r_busy  <= w_busy_nxt;
      r_q     <= w_q_nxt;
      r_qbar  <= ~w_q_nxt;
    end
  end

  assign bus.gnt_a = r_gnt_a;
  assign bus.gnt_b = r_gnt_b;
  assign bus.busy  = r_busy;
  assign bus.owner = r_owner;
  assign bus.q     = r_q;
  assign bus.qbar  = r_qbar;

endmodule

// File: tb/tb_jk_bank_sched.sv
// Self-checking bench for jk_bank_sched: directed corners plus randomized traffic against a
// command-level model of the bank.
module tb_jk_bank_sched;
  localparam int unsigned W = 8;
  localparam int unsigned C = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  jk_bank_sched_if #(.WIDTH(W), .CW(C)) bus ();

  jk_bank_sched #(.WIDTH(W), .CW(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Command-level model: a grant books cnt+1 applications; the bank is idle when none are left.
  function automatic logic [W-1:0] jk_apply(input logic [W-1:0] q, input logic [1:0] op,
                                            input logic [W-1:0] mask);
    logic [W-1:0] r;
    r = q;
    for (int i = 0; i < int'(W); i++)
      if (mask[i])
        case (op)
          2'd1:    r[i] = 1'b0;
          2'd2:    r[i] = 1'b1;
          2'd3:    r[i] = ~q[i];
          default: r[i] = q[i];
        endcase
    return r;
  endfunction

  logic [W-1:0] m_q, n_q, m_mask, n_mask;
  logic [1:0]   m_op, n_op;
  int           m_apps, n_apps;
  logic         m_owner, n_owner, m_gnt_a, n_gnt_a, m_gnt_b, n_gnt_b;
  logic [W-1:0] m_qbar;
  assign m_qbar = ~m_q;

  always_comb begin
    n_q     = m_q;
    n_mask  = m_mask;
    n_op    = m_op;
    n_apps  = m_apps;
    n_owner = m_owner;
    n_gnt_a = 1'b0;
    n_gnt_b = 1'b0;
    if (m_apps == 0) begin
      if (bus.req_a || bus.req_b) begin
        n_owner = (bus.req_a && bus.req_b) ? !m_owner : bus.req_b;
        n_op    = n_owner ? bus.op_b : bus.op_a;
        n_mask  = n_owner ? bus.mask_b : bus.mask_a;
        n_apps  = (n_owner ? 32'(bus.cnt_b) : 32'(bus.cnt_a)) + 1;
        n_gnt_a = !n_owner;
        n_gnt_b = n_owner;
      end
    end else begin
      n_q    = jk_apply(m_q, m_op, m_mask);
      n_apps = m_apps - 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0; m_mask <= '0; m_op <= '0; m_apps <= 0;
      m_owner <= 1'b1; m_gnt_a <= 1'b0; m_gnt_b <= 1'b0;
    end else begin
      m_q <= n_q; m_mask <= n_mask; m_op <= n_op; m_apps <= n_apps;
      m_owner <= n_owner; m_gnt_a <= n_gnt_a; m_gnt_b <= n_gnt_b;
    end
  end

  // every-cycle comparison, away from the active edge
  always @(negedge clk) begin
    chk("q",     32'(bus.q),     32'(m_q));
    chk("qbar",  32'(bus.qbar),  32'(m_qbar));
    chk("gnt_a", 32'(bus.gnt_a), 32'(m_gnt_a));
    chk("gnt_b", 32'(bus.gnt_b), 32'(m_gnt_b));
    chk("busy",  32'(bus.busy),  32'(m_apps != 0));
    chk("owner", 32'(bus.owner), 32'(m_owner));
  end

  logic [W-1:0] hist[$];

  task automatic idle_reqs();
    bus.req_a = 1'b0; bus.op_a = '0; bus.mask_a = '0; bus.cnt_a = '0;
    bus.req_b = 1'b0; bus.op_b = '0; bus.mask_b = '0; bus.cnt_b = '0;
  endtask

  // one command from one side; collects q after each application edge and busy length
  task automatic issue(input logic side, input logic [1:0] op, input logic [W-1:0] mask,
                       input logic [C-1:0] cnt, output int busy_cycles);
    int n;
    logic got;
    hist.delete();
    busy_cycles = 0;
    @(negedge clk);
    if (side) begin bus.req_b = 1'b1; bus.op_b = op; bus.mask_b = mask; bus.cnt_b = cnt; end
    else      begin bus.req_a = 1'b1; bus.op_a = op; bus.mask_a = mask; bus.cnt_a = cnt; end
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      got = side ? bus.gnt_b : bus.gnt_a;
      n++;
    end
    chk("grant_seen", 32'(got), 32'(1));
    @(negedge clk);
    if (side) bus.req_b = 1'b0; else bus.req_a = 1'b0;
    if (!got) return;
    busy_cycles = 1;
    n = 0;
    while (bus.busy && n < 40) begin
      @(posedge clk); #1;
      hist.push_back(bus.q);
      if (bus.busy) busy_cycles++;
      n++;
    end
    chk("busy_drop", 32'(bus.busy), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_reqs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int bc;
    logic ra, rb;
    rst_n = 1'b0;
    idle_reqs();
    repeat (2) @(negedge clk);
    chk("rst_q",    32'(bus.q),    32'h00);
    chk("rst_qbar", 32'(bus.qbar), 32'hFF);
    chk("rst_owner", 32'(bus.owner), 32'(1));
    rst_n = 1'b1;

    // async reset in the middle of a toggle run
    @(negedge clk);
    bus.req_a = 1'b1; bus.op_a = 2'd3; bus.mask_a = 8'hFF; bus.cnt_a = 4'd7;
    @(posedge clk); #1;
    chk("mr_gnt", 32'(bus.gnt_a), 32'(1));
    @(negedge clk);
    bus.req_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("mr_pre_q", 32'(bus.q), 32'hFF);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_q",    32'(bus.q),    32'h00);
    chk("mr_qbar", 32'(bus.qbar), 32'hFF);
    chk("mr_busy", 32'(bus.busy), 32'(0));
    chk("mr_gnt",  32'({bus.gnt_a, bus.gnt_b}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mr_after_q",    32'(bus.q),    32'h00);
    chk("mr_after_busy", 32'(bus.busy), 32'(0));

    // single set
    issue(1'b0, 2'd2, 8'hA5, 4'd0, bc);
    chk("set_q",     32'(bus.q), 32'hA5);
    chk("set_busy",  32'(bc), 32'(1));
    chk("set_owner", 32'(bus.owner), 32'(0));
    chk("set_hist",  32'(hist.size()), 32'(1));

    // bring bank to 0x0F, then triple toggle from B
    issue(1'b0, 2'd1, 8'hF0, 4'd0, bc);
    chk("clr_q", 32'(bus.q), 32'h05);
    issue(1'b0, 2'd2, 8'h0F, 4'd0, bc);
    chk("pre_tog_q", 32'(bus.q), 32'h0F);
    issue(1'b1, 2'd3, 8'hFF, 4'd2, bc);
    chk("tog_busy", 32'(bc), 32'(3));
    chk("tog_len",  32'(hist.size()), 32'(3));
    if (hist.size() == 3) begin
      chk("tog_e1", 32'(hist[0]), 32'hF0);
      chk("tog_e2", 32'(hist[1]), 32'h0F);
      chk("tog_e3", 32'(hist[2]), 32'hF0);
    end
    chk("tog_owner", 32'(bus.owner), 32'(1));

    // hold as a timed delay, and an empty mask
    issue(1'b0, 2'd0, 8'hFF, 4'd15, bc);
    chk("hold_busy", 32'(bc), 32'(16));
    chk("hold_q",    32'(bus.q), 32'hF0);
    issue(1'b1, 2'd1, 8'h00, 4'd0, bc);
    chk("nomask_busy", 32'(bc), 32'(1));
    chk("nomask_q",    32'(bus.q), 32'hF0);

    // B raised during A's run must wait for A's last edge
    @(negedge clk);
    bus.req_a = 1'b1; bus.op_a = 2'd3; bus.mask_a = 8'h3C; bus.cnt_a = 4'd4;
    @(posedge clk); #1;
    chk("ign_gnt_a", 32'(bus.gnt_a), 32'(1));
    @(negedge clk);
    bus.req_a = 1'b0;
    bus.req_b = 1'b1; bus.op_b = 2'd2; bus.mask_b = 8'hC3; bus.cnt_b = 4'd0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      chk("ign_gnt_b", 32'(bus.gnt_b), 32'(i == 6));
      chk("ign_busy",  32'(bus.busy),  32'((i < 5) || (i == 6)));
      if (i == 5) chk("ign_a_done_q", 32'(bus.q), 32'hCC);
    end
    @(negedge clk);
    bus.req_b = 1'b0;
    @(posedge clk); #1;
    chk("ign_b_q", 32'(bus.q), 32'hCF);

    // tie arbitration from reset: A, B, A, B every other edge
    do_reset();
    bus.req_a = 1'b1; bus.req_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("tie_gnt_a", 32'(bus.gnt_a), 32'(i % 4 == 0));
      chk("tie_gnt_b", 32'(bus.gnt_b), 32'(i % 4 == 2));
    end
    @(negedge clk);
    idle_reqs();
    repeat (3) @(negedge clk);

    // randomized traffic, requesters keep fields stable until granted
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      ra = bus.req_a;
      rb = bus.req_b;
      if (ra && bus.gnt_a) begin
        if ($urandom_range(0, 1) == 0) bus.req_a = 1'b0;
        else begin
          bus.op_a = 2'($urandom); bus.mask_a = W'($urandom); bus.cnt_a = C'($urandom_range(0, 5));
        end
      end else if (!ra && $urandom_range(0, 2) == 0) begin
        bus.req_a = 1'b1;
        bus.op_a = 2'($urandom); bus.mask_a = W'($urandom); bus.cnt_a = C'($urandom_range(0, 15));
      end
      if (rb && bus.gnt_b) begin
        if ($urandom_range(0, 1) == 0) bus.req_b = 1'b0;
        else begin
          bus.op_b = 2'($urandom); bus.mask_b = W'($urandom); bus.cnt_b = C'($urandom_range(0, 5));
        end
      end else if (!rb && $urandom_range(0, 2) == 0) begin
        bus.req_b = 1'b1;
        bus.op_b = 2'($urandom); bus.mask_b = W'($urandom); bus.cnt_b = C'($urandom_range(0, 15));
      end
      chk("gnt_excl", 32'(bus.gnt_a & bus.gnt_b), 32'(0));
    end
    @(negedge clk);
    idle_reqs();
    repeat (40) @(negedge clk);
    chk("end_busy", 32'(bus.busy), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
